// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_CH-way packet-locked arbitrated multiplexer with a one-stage
// registered valid/ready output. Round-robin (ARB_MODE=0) or fixed priority (ARB_MODE=1).
module rr_arb_mux #(
    parameter int NUM_CH    = 4,
    parameter int BITWIDTH  = 8,
    parameter int SEL_WIDTH = 2,
    parameter int ARB_MODE  = 0
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic [NUM_CH*BITWIDTH-1:0] InData,
    input  logic [NUM_CH-1:0]          InValid,
    input  logic [NUM_CH-1:0]          InLast,
    output logic [NUM_CH-1:0]          InReady,
    output logic [BITWIDTH-1:0]        DataOut,
    output logic                       OutValid,
    output logic                       OutLast,
    input  logic                       OutReady,
    output logic [SEL_WIDTH-1:0]       GrantSel,
    output logic                       Busy
);
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SEL_WIDTH-1:0] r_grant_sel;
    logic [SEL_WIDTH-1:0] r_rr_ptr;
    logic [BITWIDTH-1:0]  r_data;
    logic                 r_valid;
    logic                 r_last;

    logic [BITWIDTH-1:0]  w_ch_data [NUM_CH];
    logic [SEL_WIDTH-1:0] w_winner;
    logic [SEL_WIDTH-1:0] w_idx;
    logic                 w_found;
    logic                 w_out_free;
    logic                 w_in_accept;
    logic                 w_last_accept;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_split
        assign w_ch_data[g] = InData[g*BITWIDTH +: BITWIDTH];
    end

    // Search starts at the pointer (or channel 0) and wraps once around all channels.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = (ARB_MODE == 1) ? '0 : r_rr_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && InValid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
            w_idx = (w_idx == SEL_WIDTH'(NUM_CH - 1)) ? '0 : w_idx + SEL_WIDTH'(1);
        end
    end

    assign w_out_free    = !r_valid || OutReady;
    assign w_in_accept   = (r_state == XFER) && InValid[r_grant_sel] && w_out_free;
    assign w_last_accept = w_in_accept && InLast[r_grant_sel];

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking so every flop samples the values from before the edge.
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found)       w_state_nxt = XFER;
            XFER:    if (w_last_accept) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        InReady = '0;
        if (r_state == XFER && w_out_free) InReady[r_grant_sel] = 1'b1;
        Busy = (r_state == XFER);
    end

    // Grant is captured only in IDLE, so it stays locked for the whole packet.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_grant_sel <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (r_state == IDLE && w_found) r_grant_sel <= w_winner;
            if (ARB_MODE == 0 && w_last_accept)
                r_rr_ptr <= (r_grant_sel == SEL_WIDTH'(NUM_CH - 1)) ? '0
                                                                    : r_grant_sel + SEL_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (w_in_accept) begin
            r_data  <= w_ch_data[r_grant_sel];
            r_last  <= InLast[r_grant_sel];
            r_valid <= 1'b1;
        end else if (OutReady) begin
            r_valid <= 1'b0;
        end
    end

    assign DataOut  = r_data;
    assign OutValid = r_valid;
    assign OutLast  = r_last;
    assign GrantSel = r_grant_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: drives a round-robin and a fixed-priority instance with shared inputs,
// checking both every cycle against a transaction-level model plus directed sequences.
module tb_rr_arb_mux;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic           Clk = 1'b0;
    logic           Rst_n;
    logic [N*W-1:0] InData;
    logic [N-1:0]   InValid;
    logic [N-1:0]   InLast;
    logic           OutReady;

    logic [N-1:0] rr_rdy,  fp_rdy;
    logic [W-1:0] rr_dout, fp_dout;
    logic         rr_ov,   fp_ov;
    logic         rr_ol,   fp_ol;
    logic [1:0]   rr_gs,   fp_gs;
    logic         rr_busy, fp_busy;

    always #5 Clk = ~Clk;

    rr_arb_mux #(.NUM_CH(N), .BITWIDTH(W), .SEL_WIDTH(2), .ARB_MODE(0)) u_rr (
        .Clk(Clk), .Rst_n(Rst_n), .InData(InData), .InValid(InValid), .InLast(InLast),
        .InReady(rr_rdy), .DataOut(rr_dout), .OutValid(rr_ov), .OutLast(rr_ol),
        .OutReady(OutReady), .GrantSel(rr_gs), .Busy(rr_busy)
    );

    rr_arb_mux #(.NUM_CH(N), .BITWIDTH(W), .SEL_WIDTH(2), .ARB_MODE(1)) u_fp (
        .Clk(Clk), .Rst_n(Rst_n), .InData(InData), .InValid(InValid), .InLast(InLast),
        .InReady(fp_rdy), .DataOut(fp_dout), .OutValid(fp_ov), .OutLast(fp_ol),
        .OutReady(OutReady), .GrantSel(fp_gs), .Busy(fp_busy)
    );

    // Reference model state: index 0 = round-robin instance, 1 = fixed priority.
    bit           m_busy [2];
    bit           m_ov   [2];
    bit           m_ol   [2];
    bit           m_acc  [2];
    int           m_gsel [2];
    int           m_ptr  [2];
    logic [W-1:0] m_od   [2];
    bit           prev_busy [2];

    beat_t src_q     [N][$];
    int    obs_q     [2][$];
    int    obs_cyc   [2][$];
    int    grant_q   [2][$];
    int    grant_cyc [2][$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit checks_on = 1'b0;
    bit rand_mode = 1'b0;
    int src_inst  = 0;
    int exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string iname(input int m);
        return (m == 0) ? "rr" : "fp";
    endfunction

    function automatic logic [W-1:0] ch_data(input int ch);
        logic [N*W-1:0] v;
        v = InData >> (ch * W);
        return v[W-1:0];
    endfunction

    function automatic int winner(input int m);
        int start;
        int c;
        start = (m == 1) ? 0 : m_ptr[m];
        for (int k = 0; k < N; k++) begin
            c = (start + k) % N;
            if (InValid[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit queues_empty();
        for (int ch = 0; ch < N; ch++) if (src_q[ch].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Applies one rising edge to the model, using the inputs as seen at that edge.
    task automatic model_edge();
        int w;
        for (int m = 0; m < 2; m++) begin
            m_acc[m] = 1'b0;
            if (!Rst_n) begin
                m_busy[m] = 0; m_gsel[m] = 0; m_ptr[m] = 0;
                m_ov[m] = 0;   m_ol[m] = 0;   m_od[m] = '0;
            end else begin
                if (m_busy[m] && InValid[m_gsel[m]] && (!m_ov[m] || OutReady)) begin
                    m_acc[m] = 1'b1;
                    m_od[m]  = ch_data(m_gsel[m]);
                    m_ol[m]  = InLast[m_gsel[m]];
                    m_ov[m]  = 1'b1;
                end else if (OutReady) begin
                    m_ov[m] = 1'b0;
                end
                if (!m_busy[m]) begin
                    w = winner(m);
                    if (w >= 0) begin
                        m_gsel[m] = w;
                        m_busy[m] = 1'b1;
                    end
                end else if (m_acc[m] && InLast[m_gsel[m]]) begin
                    m_busy[m] = 1'b0;
                    if (m == 0) m_ptr[m] = (m_gsel[m] + 1) % N;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] rdy, exp_rdy;
        logic [W-1:0] dout;
        logic         ov, ol, busy;
        logic [1:0]   gs;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin
                rdy = rr_rdy; dout = rr_dout; ov = rr_ov; ol = rr_ol; busy = rr_busy; gs = rr_gs;
            end else begin
                rdy = fp_rdy; dout = fp_dout; ov = fp_ov; ol = fp_ol; busy = fp_busy; gs = fp_gs;
            end
            exp_rdy = '0;
            if (m_busy[m] && (!m_ov[m] || OutReady)) exp_rdy[m_gsel[m]] = 1'b1;
            check({iname(m), ".in_ready"},  rdy,  exp_rdy);
            check({iname(m), ".out_valid"}, ov,   m_ov[m]);
            check({iname(m), ".out_last"},  ol,   m_ol[m]);
            check({iname(m), ".data_out"},  dout, m_od[m]);
            check({iname(m), ".busy"},      busy, m_busy[m]);
            if (m_busy[m]) check({iname(m), ".grant_sel"}, gs, m_gsel[m]);
            if (ov && OutReady) begin
                obs_q[m].push_back(int'(dout));
                obs_cyc[m].push_back(cyc);
            end
            if (busy && !prev_busy[m]) begin
                grant_q[m].push_back(int'(gs));
                grant_cyc[m].push_back(cyc);
            end
            prev_busy[m] = busy;
        end
    endtask

    task automatic drive_sources();
        for (int ch = 0; ch < N; ch++) begin
            if (src_q[ch].size() > 0) begin
                InValid[ch]        = 1'b1;
                InLast[ch]         = src_q[ch][0].l;
                InData[ch*W +: W]  = src_q[ch][0].d;
            end else begin
                InValid[ch]        = 1'b0;
                InLast[ch]         = 1'b0;
                InData[ch*W +: W]  = '0;
            end
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model at posedge.
    task automatic step();
        @(negedge Clk);
        if (!rand_mode) drive_sources();
        #1;
        if (checks_on) check_outputs();
        @(posedge Clk);
        model_edge();
        if (!Rst_n) checks_on = 1'b1;
        if (!rand_mode && m_acc[src_inst]) void'(src_q[m_gsel[src_inst]].pop_front());
        cyc++;
        #1;
    endtask

    task automatic push_beat(input int ch, input logic [W-1:0] d, input logic l);
        src_q[ch].push_back(beat_t'{d: d, l: l});
    endtask

    task automatic push_pkt(input int ch, input int base, input int len);
        for (int b = 0; b < len; b++) push_beat(ch, W'(base + b), b == len - 1);
    endtask

    task automatic clear_obs();
        for (int m = 0; m < 2; m++) begin
            obs_q[m].delete(); obs_cyc[m].delete();
            grant_q[m].delete(); grant_cyc[m].delete();
        end
    endtask

    task automatic run_until_done(input int m, input int budget);
        int n;
        n = 0;
        while (!(queues_empty() && !m_busy[m] && !m_ov[m])) begin
            if (n == budget) begin
                check("drain_timeout", {31'b0, !queues_empty() | m_busy[m] | m_ov[m]}, 32'd0);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic wait_grant(input int m, input int ch, input int budget);
        int n;
        n = 0;
        while (!(m_busy[m] && m_gsel[m] == ch)) begin
            if (n == budget) begin
                check("grant_timeout", {31'b0, m_busy[m]}, 32'd1);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check({tag, ".len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic check_gaps(input string tag, input int cy[$], input int gap);
        for (int i = 1; i < cy.size(); i++)
            check($sformatf("%s[%0d]", tag, i), cy[i] - cy[i-1], gap);
    endtask

    initial begin
        Rst_n = 1'b0; OutReady = 1'b1; InValid = '0; InLast = '0; InData = '0;

        // Reset with all channels requesting, then round-robin fairness.
        push_pkt(0, 'h00, 2); push_pkt(1, 'h10, 2); push_pkt(2, 'h20, 2);
        push_pkt(3, 'h30, 2); push_pkt(0, 'h00, 2);
        step(); step();
        check("rst.busy", rr_busy, 0);
        check("rst.out_valid", rr_ov, 0);
        check("rst.in_ready", rr_rdy, 0);
        Rst_n = 1'b1;
        #1;
        check("rel.idle", rr_busy, 0);
        step();
        check("rel.busy", rr_busy, 1);
        check("rel.grant", rr_gs, 0);
        run_until_done(0, 60);
        exp_q = {0, 1, 2, 3, 0};
        check_seq("rr.grants", grant_q[0], exp_q);
        exp_q = {'h00, 'h01, 'h10, 'h11, 'h20, 'h21, 'h30, 'h31, 'h00, 'h01};
        check_seq("rr.beats", obs_q[0], exp_q);
        check_gaps("rr.grant_gap", grant_cyc[0], 3);

        // Packet lock: ch0 requests while ch2 is mid-packet.
        clear_obs();
        push_pkt(2, 'h20, 4);
        wait_grant(0, 2, 20);
        step();
        push_pkt(0, 'h05, 1);
        run_until_done(0, 40);
        exp_q = {2, 0};
        check_seq("lock.grants", grant_q[0], exp_q);
        check_gaps("lock.grant_gap", grant_cyc[0], 5);
        exp_q = {'h20, 'h21, 'h22, 'h23, 'h05};
        check_seq("lock.beats", obs_q[0], exp_q);

        // Backpressure: three stalled cycles with A5 held on the output.
        clear_obs();
        push_beat(1, 8'hA5, 1'b0); push_beat(1, 8'h5A, 1'b1);
        wait_grant(0, 1, 20);
        step();
        for (int i = 0; i < 3; i++) begin
            OutReady = 1'b0;
            #1;
            check("bp.out_valid", rr_ov, 1);
            check("bp.data_hold", rr_dout, 8'hA5);
            check("bp.in_ready1", rr_rdy[1], 0);
            step();
        end
        OutReady = 1'b1;
        run_until_done(0, 20);
        exp_q = {'hA5, 'h5A};
        check_seq("bp.beats", obs_q[0], exp_q);
        check_gaps("bp.beat_gap", obs_cyc[0], 1);

        // Fixed priority: ch1 beats ch3, and ch1 re-requesting wins again.
        src_inst = 1;
        Rst_n = 1'b0; step(); Rst_n = 1'b1;
        clear_obs();
        push_pkt(3, 'h33, 1); push_pkt(1, 'h11, 1); push_pkt(1, 'h12, 1);
        run_until_done(1, 30);
        exp_q = {1, 1, 3};
        check_seq("fp.grants", grant_q[1], exp_q);
        check_gaps("fp.grant_gap", grant_cyc[1], 2);
        exp_q = {'h11, 'h12, 'h33};
        check_seq("fp.beats", obs_q[1], exp_q);

        // Reset mid-packet with the round-robin pointer parked at 2.
        src_inst = 0;
        Rst_n = 1'b0; step(); Rst_n = 1'b1;
        push_pkt(1, 'h77, 1);
        run_until_done(0, 20);
        push_pkt(0, 'hC0, 4);
        wait_grant(0, 0, 20);
        step();
        Rst_n = 1'b0;
        step();
        check("mrst.out_valid", rr_ov, 0);
        check("mrst.busy", rr_busy, 0);
        check("mrst.in_ready", rr_rdy, 0);
        for (int ch = 0; ch < N; ch++) src_q[ch].delete();
        Rst_n = 1'b1;
        clear_obs();
        push_pkt(3, 'h3A, 1); push_pkt(0, 'h0A, 1);
        run_until_done(0, 20);
        exp_q = {0, 3};
        check_seq("mrst.grants", grant_q[0], exp_q);
        exp_q = {'h0A, 'h3A};
        check_seq("mrst.beats", obs_q[0], exp_q);

        // Randomized traffic with occasional resets, both instances against the model.
        rand_mode = 1'b1;
        Rst_n = 1'b0;
        step();
        for (int i = 0; i < 2000; i++) begin
            Rst_n    = ($urandom_range(0, 199) != 0);
            OutReady = ($urandom_range(0, 3) != 0);
            InValid  = N'($urandom) | N'($urandom);
            InLast   = N'($urandom) & N'($urandom);
            InData   = (N*W)'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, packet-aware arbitrated multiplexer; successor to the fixed 4:1 combinational data mux.
- Merges NUM_CH valid/ready request streams, e.g. SDRAM controller command/write-data sources, onto the single unidirectional bus.
- Arbitration is round-robin or fixed-priority. A grant is held for a whole packet, until an accepted beat with InLast set.
- Output is registered, one stage, with full valid/ready backpressure.

Parameters:
- NUM_CH, 4: number of input channels, 2..16.
- BITWIDTH, 8: data bits per channel.
- SEL_WIDTH, 2: grant index width; must equal ceil(log2(NUM_CH)).
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, channel 0 highest.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst_n, input, 1: synchronous active-low reset.
- InData, input, NUM_CH*BITWIDTH: channel i occupies bits [(i+1)*BITWIDTH-1 : i*BITWIDTH].
- InValid, input, NUM_CH: per-channel beat valid.
- InLast, input, NUM_CH: per-channel last beat of packet; qualified by InValid.
- InReady, output, NUM_CH: per-channel beat accept.
- DataOut, output, BITWIDTH: registered output data.
- OutValid, output, 1: registered output valid.
- OutLast, output, 1: registered last flag for the beat on DataOut.
- OutReady, input, 1: downstream accept.
- GrantSel, output, SEL_WIDTH: index of the granted channel; meaningful only while Busy=1.
- Busy, output, 1: high while a packet grant is held (state XFER).

Behaviour:
- Reset: Clk and Rst_n only; Rst_n is synchronous, active-low. When Rst_n=0 at a rising edge:
  - state <= IDLE; OutValid, OutLast, DataOut, GrantSel, Busy <= 0; round-robin pointer <= 0.
  - Reset mid-packet abandons the packet. No partial beat is held, and InReady is 0 from the following cycle.
- Beat transfer:
  - Input beat accepted on channel i in a cycle where InValid[i] && InReady[i].
  - Output beat accepted in a cycle where OutValid && OutReady.
- InReady:
  - InReady[i] = (state==XFER) && (GrantSel==i) && (!OutValid || OutReady).
  - Combinational from OutReady. All other bits are 0.
- State machine:
  - IDLE: Busy=0, no InReady. If any InValid bit is set, choose winner w. Next edge: GrantSel<=w, Busy<=1, state<=XFER. Otherwise stay in IDLE.
  - XFER: accept beats from GrantSel only. When an accepted beat has InLast[GrantSel]=1, the next edge sets state<=IDLE and Busy<=0. In round-robin mode the same edge sets pointer <= (GrantSel+1) mod NUM_CH.
- Arbitration:
  - Round-robin: w is the first channel with InValid set, searching pointer, pointer+1, … with wrap at NUM_CH-1 -> 0.
  - Fixed priority: w is the lowest set index.
  - InLast and InValid of non-granted channels are ignored during XFER.
- Output register:
  - On input accept: DataOut, OutLast <= granted channel's data and last; OutValid<=1.
  - Else if OutReady: OutValid<=0.
  - DataOut and OutLast hold while OutValid && !OutReady.
- Latency and throughput:
  - Request seen in IDLE at cycle t -> grant at t+1 -> first beat accepted at t+1 -> OutValid at t+2.
  - Throughput is 1 beat/cycle within a packet while OutReady=1.
  - Exactly one IDLE cycle (bubble) between consecutive packets.
- Boundary conditions:
  - Single-beat packet (InLast with the first beat): XFER lasts one cycle.
  - InValid on the granted channel dropping mid-packet: grant is held indefinitely; no timeout.
  - Simultaneous last-beat accept and OutReady=0 on a full register: cannot occur, because InReady=0 in that case.
  - Grant locking is guaranteed: no switch occurs before an accepted InLast, regardless of other requests.
  - Requests asserted or deasserted in the same IDLE cycle are sampled as-is; the winner is decided from the value in that cycle.

Test Plan:
- Reset and idle check: hold Rst_n=0 for 2 cycles with InValid=4'b1111, then release.
  - During reset: OutValid=0, InReady=0, Busy=0.
  - First cycle after release: still idle.
  - Grant to ch0 follows on the next edge.
- Round-robin fairness: NUM_CH=4, all channels continuously requesting, each sending 2-beat packets (data = 8'h10*ch + beat).
  - Grant order is 0,1,2,3,0.
  - DataOut sequence is 00,01,10,11,20,21,30,31, with a one-cycle bubble between packets.
- Packet lock: ch2 is sending a 4-beat packet while ch0 asserts InValid from beat 1.
  - GrantSel stays at 2 until the InLast beat is accepted.
  - ch0 is granted one IDLE cycle later.
- Backpressure: OutReady=0 for 3 cycles mid-packet, ch1 data 8'hA5, 8'h5A.
  - DataOut holds A5 with OutValid=1, and InReady[1]=0.
  - After OutReady=1, 5A follows on consecutive cycles.
  - No beats are lost or duplicated.
- Fixed priority: ARB_MODE=1, ch3 and ch1 request simultaneously with single-beat packets.
  - ch1 is granted first, then ch3.
  - If ch1 re-requests before ch3's grant, ch1 wins again (starvation allowed).
- Reset mid-packet: assert Rst_n=0 during beat 2 of a 4-beat ch0 packet.
  - Next cycle: OutValid=0, Busy=0, round-robin pointer=0.
  - After release, a fresh arbitration grants the lowest requesting channel.
